// File: rtl/box_cmd_sequencer_pkg.sv
// Shared types and constants for the box drawer command sequencer.
package box_cmd_sequencer_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_X    = 3'd1;
  localparam logic [2:0] ST_Y    = 3'd2;
  localparam logic [2:0] ST_GO   = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_WAIT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_X    = ST_X,
    S_Y    = ST_Y,
    S_GO   = ST_GO,
    S_GAP  = ST_GAP,
    S_WAIT = ST_WAIT
  } state_t;

  localparam int BOX_SIZE = 4;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [3:0]  DEF_PULSE_LEN = 4'd2;
  localparam logic [14:0] DEF_TIMEOUT   = 15'd20000;

  function automatic logic [6:0] clamp7(input logic [6:0] v, input logic [6:0] vmax);
    return (v > vmax) ? vmax : v;
  endfunction

endpackage

// File: rtl/box_cmd_sequencer_if.sv
// Command channel (valid/ready plus payload) into the box drawer sequencer.
interface box_cmd_sequencer_if;
  logic       iCmdValid;
  logic       oCmdReady;
  logic       iCmdClear;
  logic [6:0] iCmdX;
  logic [6:0] iCmdY;
  logic [2:0] iCmdColour;

  modport master (
    output iCmdValid, iCmdClear, iCmdX, iCmdY, iCmdColour,
    input  oCmdReady
  );

  modport slave (
    input  iCmdValid, iCmdClear, iCmdX, iCmdY, iCmdColour,
    output oCmdReady
  );
endinterface

// File: rtl/box_cmd_counter.sv
// Loadable up-counter that stops at a terminal value and flags it.
module box_cmd_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  assign o_tc = (r_count == i_term);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/box_cmd_sequencer.sv
// Turns draw/clear commands into the box drawer's load-X / plot / black pulse
// protocol and waits for the drawer's done handshake.
module box_cmd_sequencer
  import box_cmd_sequencer_pkg::*;
#(
  parameter logic [3:0]  PULSE_LEN = DEF_PULSE_LEN,
  parameter logic [6:0]  X_MAX     = 7'd124,
  parameter logic [6:0]  Y_MAX     = 7'(SCREEN_H - BOX_SIZE),
  parameter logic [14:0] TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                  iClock,
  input  logic                  iReset,
  box_cmd_sequencer_if.slave    cmd,
  input  logic                  iDone,
  output logic                  oLoadX,
  output logic [6:0]            oXY_Coord,
  output logic [2:0]            oColour,
  output logic                  oPlotBox,
  output logic                  oBlack,
  output logic                  oBusy,
  output logic                  oTimeout
);

  state_t     r_state;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_seen_low;

  logic w_ready;
  logic w_accept;
  logic w_pulse_load;
  logic w_pulse_en;
  logic w_pulse_tc;
  logic w_wait_load;
  logic w_wait_en;
  logic w_wait_tc;

  assign w_ready       = (r_state == S_IDLE) && !iReset;
  assign w_accept      = cmd.iCmdValid && w_ready;
  assign cmd.oCmdReady = w_ready;

  // Counters are preloaded with 1 so the count equals the cycle index within the state.
  always_comb begin
    w_pulse_load = 1'b0;
    w_pulse_en   = 1'b0;
    w_wait_load  = 1'b0;
    w_wait_en    = 1'b0;
    case (r_state)
      S_IDLE: w_pulse_load = w_accept;
      S_X:    w_pulse_en   = 1'b1;
      S_Y:    w_pulse_load = 1'b1;
      S_GO:   w_pulse_en   = 1'b1;
      S_GAP:  w_wait_load  = 1'b1;
      S_WAIT: w_wait_en    = 1'b1;
      default: begin
        w_pulse_load = 1'b0;
        w_wait_load  = 1'b0;
      end
    endcase
  end

  box_cmd_counter #(.W(4)) u_pulse_cnt (
    .i_clk      (iClock),
    .i_rst      (iReset),
    .i_load     (w_pulse_load),
    .i_load_val (4'd1),
    .i_en       (w_pulse_en),
    .i_term     (PULSE_LEN),
    .o_tc       (w_pulse_tc)
  );

  box_cmd_counter #(.W(15)) u_wait_cnt (
    .i_clk      (iClock),
    .i_rst      (iReset),
    .i_load     (w_wait_load),
    .i_load_val (15'd1),
    .i_en       (w_wait_en),
    .i_term     (TIMEOUT),
    .o_tc       (w_wait_tc)
  );

  // Sequencer FSM; every drawer-facing output is registered here.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state    <= S_IDLE;
      r_y        <= 7'd0;
      r_colour   <= 3'd0;
      r_seen_low <= 1'b0;
      oLoadX     <= 1'b0;
      oXY_Coord  <= 7'd0;
      oColour    <= 3'd0;
      oPlotBox   <= 1'b0;
      oBlack     <= 1'b0;
      oBusy      <= 1'b0;
      oTimeout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_y      <= clamp7(cmd.iCmdY, Y_MAX);
            r_colour <= cmd.iCmdColour;
            oTimeout <= 1'b0;
            oBusy    <= 1'b1;
            if (cmd.iCmdClear) begin
              r_state    <= S_GO;
              r_seen_low <= 1'b0;
              oBlack     <= 1'b1;
            end else begin
              r_state   <= S_X;
              oLoadX    <= 1'b1;
              oXY_Coord <= clamp7(cmd.iCmdX, X_MAX);
            end
          end
        end
        S_X: begin
          if (w_pulse_tc) begin
            r_state   <= S_Y;
            oLoadX    <= 1'b0;
            oXY_Coord <= r_y;
            oColour   <= r_colour;
          end
        end
        S_Y: begin
          r_state    <= S_GO;
          r_seen_low <= 1'b0;
          oPlotBox   <= 1'b1;
        end
        S_GO: begin
          if (w_pulse_tc) begin
            r_state  <= S_GAP;
            oPlotBox <= 1'b0;
            oBlack   <= 1'b0;
          end
        end
        S_GAP: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done that never dropped since S_GO is stale from the previous command.
          if (!iDone) begin
            r_seen_low <= 1'b1;
          end
          if (r_seen_low && iDone) begin
            r_state <= S_IDLE;
            oBusy   <= 1'b0;
          end else if (w_wait_tc) begin
            r_state  <= S_IDLE;
            oBusy    <= 1'b0;
            oTimeout <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          oLoadX   <= 1'b0;
          oPlotBox <= 1'b0;
          oBlack   <= 1'b0;
          oBusy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
